// File: rtl/game_pkg.sv
// Shared definitions for the snake game controller: state encodings,
// default timing constants, score width and the move-period helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int SCORE_W = 8;

    localparam int unsigned DEF_TICK_BASE     = 32'd10000000;
    localparam int unsigned DEF_TICK_STEP     = 32'd500000;
    localparam int unsigned DEF_TICK_MIN      = 32'd2000000;
    localparam int unsigned DEF_LEVEL_SHIFT   = 32'd3;
    localparam int unsigned DEF_BLINK_CYC     = 32'd25000000;
    localparam int unsigned DEF_OVER_HOLD_CYC = 32'd300000000;

    // Move period for a given score: base minus one step per level,
    // clamped at the floor before it could ever go below it.
    function automatic logic [31:0] period_f(
        input logic [SCORE_W-1:0] score,
        input logic [31:0]        base,
        input logic [31:0]        step,
        input logic [31:0]        tmin,
        input logic [31:0]        shift
    );
        logic [31:0] lvl;
        logic [31:0] red;
        logic [31:0] res;
        lvl = {{(32-SCORE_W){1'b0}}, score} >> shift;
        red = lvl * step;
        if (red >= (base - tmin)) begin
            res = tmin;
        end else begin
            res = base - red;
        end
        return res;
    endfunction

endpackage

// File: rtl/game_sequencer_tick_gen.sv
// Programmable down-counter used for the snake move period.
// Load has priority over enable; the counter sticks at zero until reloaded.
module tick_gen #(
    parameter int W = 8
) (
    input  logic         I_clk,
    input  logic         I_rst,
    input  logic         I_load,
    input  logic         I_en,
    input  logic [W-1:0] I_load_val,
    output logic         O_zero
);

    logic [W-1:0] r_cnt;

    // Counter register: load, else decrement toward zero, else hold.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_cnt <= {W{1'b0}};
        end else if (I_load) begin
            r_cnt <= I_load_val;
        end else if (I_en && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign O_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/game_sequencer.sv
// Top-level game controller: IDLE/RUN/PAUSE/OVER state machine, move-tick
// scheduling with score-dependent period, restart pulses and OVER blink.
// Optional build macro GAME_AUTO_RESTART_EN: OVER falls back to IDLE after
// OVER_HOLD_CYC cycles without a start press.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICK_BASE     = DEF_TICK_BASE,
    parameter int unsigned TICK_STEP     = DEF_TICK_STEP,
    parameter int unsigned TICK_MIN      = DEF_TICK_MIN,
    parameter int unsigned LEVEL_SHIFT   = DEF_LEVEL_SHIFT,
    parameter int unsigned BLINK_CYC     = DEF_BLINK_CYC,
    parameter int unsigned OVER_HOLD_CYC = DEF_OVER_HOLD_CYC
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_start,
    input  logic               I_pause,
    input  logic               I_collide,
    input  logic               I_eat,
    input  logic [SCORE_W-1:0] I_score,
    output logic [1:0]         O_state,
    output logic               O_move_tick,
    output logic               O_snake_clear,
    output logic               O_score_clr,
    output logic               O_box_drive,
    output logic               O_blank
);

    localparam int CNT_W   = (TICK_BASE > 32'd1) ? $clog2(TICK_BASE) : 1;
    localparam int BLINK_W = (BLINK_CYC > 32'd1) ? $clog2(BLINK_CYC) : 1;

    // Reload value on RUN entry: period at score zero, minus one.
    localparam logic [CNT_W-1:0] P0_M1 =
        CNT_W'(period_f({SCORE_W{1'b0}}, TICK_BASE, TICK_STEP, TICK_MIN, LEVEL_SHIFT) - 32'd1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_run_entry;
    logic               w_run_go;
    logic               w_cnt_zero;
    logic               w_tc_load;
    logic [CNT_W-1:0]   w_tc_load_val;
    logic [31:0]        w_period;
    logic               w_stay_over;
    logic               w_blink_wrap;
    logic [BLINK_W-1:0] r_blink_cnt;

    logic w_move_tick_nxt;
    logic w_snake_clear_nxt;
    logic w_score_clr_nxt;
    logic w_box_drive_nxt;
    logic w_blank_nxt;

    logic r_move_tick;
    logic r_snake_clear;
    logic r_score_clr;
    logic r_box_drive;
    logic r_blank;

`ifdef GAME_AUTO_RESTART_EN
    localparam int HOLD_W = (OVER_HOLD_CYC > 32'd1) ? $clog2(OVER_HOLD_CYC) : 1;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_hold_done;
    assign w_hold_done = (r_state == ST_OVER) &&
                         (r_hold_cnt == HOLD_W'(OVER_HOLD_CYC - 32'd1));
`endif

    // Counting is live only in RUN when neither a collision nor a pause
    // request claims the cycle; both freeze the counter and suppress a tick.
    assign w_run_go    = (r_state == ST_RUN) && !I_collide && !I_pause;
    assign w_run_entry = ((r_state == ST_IDLE) || (r_state == ST_OVER)) &&
                         (w_state_nxt == ST_RUN);
    assign w_stay_over = (r_state == ST_OVER) && (w_state_nxt == ST_OVER);
    assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_CYC - 32'd1));

    assign w_period      = period_f(I_score, TICK_BASE, TICK_STEP, TICK_MIN, LEVEL_SHIFT);
    assign w_tc_load     = w_run_entry || (w_run_go && w_cnt_zero);
    assign w_tc_load_val = w_run_entry ? P0_M1 : CNT_W'(w_period - 32'd1);

    tick_gen #(
        .W (CNT_W)
    ) u_tick_gen (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_load     (w_tc_load),
        .I_en       (w_run_go),
        .I_load_val (w_tc_load_val),
        .O_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode with per-state input priority.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (I_collide) begin
                    w_state_nxt = ST_OVER;
                end else if (I_pause) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (I_pause || I_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (I_start) begin
                    w_state_nxt = ST_RUN;
`ifdef GAME_AUTO_RESTART_EN
                end else if (w_hold_done) begin
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_state_nxt = ST_OVER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: values the output registers take at the next edge.
    always_comb begin
        w_move_tick_nxt   = 1'b0;
        w_snake_clear_nxt = 1'b0;
        w_score_clr_nxt   = 1'b0;
        w_box_drive_nxt   = 1'b0;
        w_blank_nxt       = 1'b0;
        w_move_tick_nxt   = w_run_go && w_cnt_zero;
        w_snake_clear_nxt = w_run_entry;
        w_score_clr_nxt   = w_run_entry;
        // A collision swallows a simultaneous eat.
        w_box_drive_nxt   = w_run_entry || ((r_state == ST_RUN) && !I_collide && I_eat);
        if (w_stay_over) begin
            w_blank_nxt = w_blink_wrap ? ~r_blank : r_blank;
        end else begin
            w_blank_nxt = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_move_tick   <= 1'b0;
            r_snake_clear <= 1'b0;
            r_score_clr   <= 1'b0;
            r_box_drive   <= 1'b0;
            r_blank       <= 1'b0;
        end else begin
            r_move_tick   <= w_move_tick_nxt;
            r_snake_clear <= w_snake_clear_nxt;
            r_score_clr   <= w_score_clr_nxt;
            r_box_drive   <= w_box_drive_nxt;
            r_blank       <= w_blank_nxt;
        end
    end

    // Blink half-period counter, restarted on every OVER entry.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_blink_cnt <= {BLINK_W{1'b0}};
        end else if (w_stay_over) begin
            r_blink_cnt <= w_blink_wrap ? {BLINK_W{1'b0}}
                                        : r_blink_cnt + {{(BLINK_W-1){1'b0}}, 1'b1};
        end else begin
            r_blink_cnt <= {BLINK_W{1'b0}};
        end
    end

`ifdef GAME_AUTO_RESTART_EN
    // OVER dwell counter driving the automatic fall-back to IDLE.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_hold_cnt <= {HOLD_W{1'b0}};
        end else if (w_stay_over) begin
            r_hold_cnt <= r_hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
            r_hold_cnt <= {HOLD_W{1'b0}};
        end
    end
`endif

    assign O_state       = r_state;
    assign O_move_tick   = r_move_tick;
    assign O_snake_clear = r_snake_clear;
    assign O_score_clr   = r_score_clr;
    assign O_box_drive   = r_box_drive;
    assign O_blank       = r_blank;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small timing parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge,
// so each sample shows the registers for the cycle whose inputs are set now.
module tb_game_sequencer;

    logic       I_clk;
    logic       I_rst;
    logic       I_start;
    logic       I_pause;
    logic       I_collide;
    logic       I_eat;
    logic [7:0] I_score;
    logic [1:0] O_state;
    logic       O_move_tick;
    logic       O_snake_clear;
    logic       O_score_clr;
    logic       O_box_drive;
    logic       O_blank;

    int n_tests;
    int n_fail;

    game_sequencer #(
        .TICK_BASE     (20),
        .TICK_STEP     (4),
        .TICK_MIN      (8),
        .LEVEL_SHIFT   (1),
        .BLINK_CYC     (4),
        .OVER_HOLD_CYC (16)
    ) dut (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_start       (I_start),
        .I_pause       (I_pause),
        .I_collide     (I_collide),
        .I_eat         (I_eat),
        .I_score       (I_score),
        .O_state       (O_state),
        .O_move_tick   (O_move_tick),
        .O_snake_clear (O_snake_clear),
        .O_score_clr   (O_score_clr),
        .O_box_drive   (O_box_drive),
        .O_blank       (O_blank)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Cycles from now until the next visible move tick, capped at 64.
    task automatic next_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!O_move_tick && n < 64);
    endtask

    task automatic check_entry(input string tag);
        check_eq({tag, "_state"}, int'(O_state), 1);
        check_eq({tag, "_snake_clr"}, int'(O_snake_clear), 1);
        check_eq({tag, "_score_clr"}, int'(O_score_clr), 1);
        check_eq({tag, "_box"}, int'(O_box_drive), 1);
        check_eq({tag, "_blank"}, int'(O_blank), 0);
    endtask

    initial begin
        int n;
        int ticks;
        n_tests   = 0;
        n_fail    = 0;
        I_rst     = 1'b1;
        I_start   = 1'b0;
        I_pause   = 1'b0;
        I_collide = 1'b0;
        I_eat     = 1'b0;
        I_score   = 8'd0;
        step_n(3);
        I_rst = 1'b0;

        // Reset state
        check_eq("rst_state", int'(O_state), 0);
        check_eq("rst_tick", int'(O_move_tick), 0);
        check_eq("rst_snake_clr", int'(O_snake_clear), 0);
        check_eq("rst_score_clr", int'(O_score_clr), 0);
        check_eq("rst_box", int'(O_box_drive), 0);
        check_eq("rst_blank", int'(O_blank), 0);

        // Pause is ignored in IDLE
        step_n(2);
        I_pause = 1'b1; step(); I_pause = 1'b0;
        check_eq("idle_pause_ignored", int'(O_state), 0);

        // Start at cycle 5: one-cycle entry pulses, first tick 20 after entry
        step_n(2);
        I_start = 1'b1; step(); I_start = 1'b0;
        check_entry("entry1");
        check_eq("entry1_tick", int'(O_move_tick), 0);
        step();
        check_eq("entry1_snake_clr_drop", int'(O_snake_clear), 0);
        check_eq("entry1_score_clr_drop", int'(O_score_clr), 0);
        check_eq("entry1_box_drop", int'(O_box_drive), 0);
        next_tick(n); check_eq("first_tick_after_k1", n, 19);
        next_tick(n); check_eq("tick_p20", n, 20);

        // Period scaling: score sampled at the zero cycle sets the following gap
        I_score = 8'd6;
        next_tick(n); check_eq("tick_s6_old", n, 20);
        next_tick(n); check_eq("tick_s6", n, 8);
        I_score = 8'd10;
        next_tick(n); check_eq("tick_s10_old", n, 8);
        next_tick(n); check_eq("tick_s10_clamp", n, 8);
        I_score = 8'd2;
        next_tick(n); check_eq("tick_s2_old", n, 8);
        next_tick(n); check_eq("tick_s2", n, 16);
        I_score = 8'd0;
        next_tick(n); check_eq("tick_s0_old", n, 16);
        next_tick(n); check_eq("tick_s0", n, 20);

        // Pause 7 cycles after a tick, hold 100 cycles, collide ignored
        step_n(7);
        I_pause = 1'b1; step(); I_pause = 1'b0;
        check_eq("pause_state", int'(O_state), 2);
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            I_collide = (i == 50) ? 1'b1 : 1'b0;
            step();
            if (O_move_tick) ticks++;
        end
        I_collide = 1'b0;
        check_eq("pause_no_ticks", ticks, 0);
        check_eq("pause_collide_ignored", int'(O_state), 2);
        I_pause = 1'b1; step(); I_pause = 1'b0;
        check_eq("resume_state", int'(O_state), 1);
        next_tick(n); check_eq("resume_tick", n, 13);

        // Collide together with eat on the zero cycle
        step_n(19);
        I_collide = 1'b1; I_eat = 1'b1; step(); I_collide = 1'b0; I_eat = 1'b0;
        check_eq("over_state", int'(O_state), 3);
        check_eq("over_tick_suppressed", int'(O_move_tick), 0);
        check_eq("over_no_box", int'(O_box_drive), 0);
        check_eq("over_blank_k0", int'(O_blank), 0);
        step_n(3); check_eq("over_blank_k3", int'(O_blank), 0);
        step();    check_eq("over_blank_k4", int'(O_blank), 1);
        check_eq("over_no_tick_k4", int'(O_move_tick), 0);
        step_n(3); check_eq("over_blank_k7", int'(O_blank), 1);
        step();    check_eq("over_blank_k8", int'(O_blank), 0);
        step();
        I_start = 1'b1; step(); I_start = 1'b0;
        check_entry("entry2");

        // Eat in RUN gives a box request on the following cycle
        step(); check_eq("eat_box_idle", int'(O_box_drive), 0);
        I_eat = 1'b1; step(); I_eat = 1'b0;
        check_eq("eat_box", int'(O_box_drive), 1);
        step(); check_eq("eat_box_drop", int'(O_box_drive), 0);

        // Reset mid-RUN drops pending pulses
        I_rst = 1'b1; I_eat = 1'b1; step(); I_rst = 1'b0; I_eat = 1'b0;
        check_eq("midrst_state", int'(O_state), 0);
        check_eq("midrst_tick", int'(O_move_tick), 0);
        check_eq("midrst_box", int'(O_box_drive), 0);
        check_eq("midrst_snake_clr", int'(O_snake_clear), 0);
        step(); check_eq("midrst_box_dropped", int'(O_box_drive), 0);

        // Start and pause together in IDLE: start wins
        I_start = 1'b1; I_pause = 1'b1; step(); I_start = 1'b0; I_pause = 1'b0;
        check_entry("entry3");
        next_tick(n); check_eq("entry3_tick", n, 20);

        // OVER dwell: auto build returns to IDLE at 16 cycles
        I_collide = 1'b1; step(); I_collide = 1'b0;
        check_eq("over2_state", int'(O_state), 3);
        step_n(15);
        check_eq("over2_k15_state", int'(O_state), 3);
        check_eq("over2_k15_blank", int'(O_blank), 1);
        step();
`ifdef GAME_AUTO_RESTART_EN
        check_eq("over2_k16_state", int'(O_state), 0);
`else
        check_eq("over2_k16_state", int'(O_state), 3);
`endif
        check_eq("over2_k16_blank", int'(O_blank), 0);
        I_start = 1'b1; step(); I_start = 1'b0;
        check_eq("restart_state", int'(O_state), 1);

        // Start at cycle 10 of OVER restarts immediately in either build
        I_collide = 1'b1; step(); I_collide = 1'b0;
        step_n(10);
        check_eq("over3_k10_state", int'(O_state), 3);
        I_start = 1'b1; step(); I_start = 1'b0;
        check_entry("entry4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game controller for the VGA snake game. Owns the game state (IDLE/RUN/PAUSE/OVER) and schedules snake movement.
- Emits one-cycle move strobes to the snake datapath.
- Issues restart clears to the snake and score blocks.
- Requests new boxes from the random box generator.
- Shortens the move period as score rises.

Parameters:
- TICK_BASE, 10000000: move period in clocks at level 0 (100 ms at 100 MHz).
- TICK_STEP, 500000: period reduction per level.
- TICK_MIN, 2000000: floor on the move period.
- LEVEL_SHIFT, 3: level = I_score >> LEVEL_SHIFT.
- BLINK_CYC, 25000000: O_blank half-period while in OVER.
- OVER_HOLD_CYC, 300000000: OVER dwell before auto-return (optional feature only).

Ports:
- I_clk  in  1  system clock.
- I_rst  in  1  synchronous, active-high reset.
- I_start  in  1  one-cycle debounced pulse (any direction key).
- I_pause  in  1  one-cycle debounced pulse.
- I_collide  in  1  level from snake: head hit wall/body.
- I_eat  in  1  one-cycle pulse from snake: head on box.
- I_score  in  8  current score.
- O_state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- O_move_tick  out  1  one-cycle move strobe.
- O_snake_clear  out  1  one-cycle snake re-init pulse.
- O_score_clr  out  1  one-cycle score clear pulse.
- O_box_drive  out  1  one-cycle new-box request.
- O_blank  out  1  display blank during OVER blink.

Behaviour:
- Reset (synchronous, I_rst=1 at an edge):
  - State IDLE; all outputs 0; tick counter and blink counter 0.
  - Applies mid-operation too: pulses are dropped and nothing is completed.
- IDLE:
  - I_start goes to RUN.
  - I_pause is ignored.
  - If I_start and I_pause arrive in the same cycle, start wins.
- Entering RUN from IDLE or OVER:
  - In the first RUN cycle, O_snake_clear, O_score_clr and O_box_drive are each high for exactly 1 cycle.
  - The tick counter is loaded with P0 = period(score=0) - 1.
- Period rule:
  - lvl = I_score >> LEVEL_SHIFT; red = lvl * TICK_STEP (32-bit).
  - period = TICK_MIN when red >= TICK_BASE - TICK_MIN; otherwise period = TICK_BASE - red.
  - There is no underflow; the counter width is clog2(TICK_BASE).
- RUN timing:
  - The counter decrements each cycle.
  - When the counter reaches 0, O_move_tick is high for that cycle and the counter reloads with period(I_score sampled that cycle) - 1.
  - First tick occurs P cycles after RUN entry; later ticks are spaced by the freshly computed period.
- RUN priority, per cycle:
  1. I_collide: next state OVER. O_move_tick is suppressed that cycle and I_eat is ignored (no O_box_drive).
  2. I_pause: next state PAUSE. The counter freezes and a tick due that cycle is suppressed; the counter holds 0 until resume.
  3. I_eat: O_box_drive high for 1 cycle on the next cycle.
  4. I_start: ignored in RUN.
- PAUSE:
  - Counter frozen; no ticks.
  - I_pause or I_start returns to RUN, and counting resumes from the frozen value.
  - I_collide is ignored.
- OVER:
  - No ticks.
  - O_blank toggles every BLINK_CYC cycles, starting at 0 on entry.
  - I_start goes to RUN, with O_blank=0 and the entry pulses above.
- At most one O_move_tick per cycle; O_box_drive is never high in the same cycle as O_move_tick of a collision.

Optional Feature:
- Macro: GAME_AUTO_RESTART_EN.
- Defined: after OVER_HOLD_CYC cycles in OVER with no I_start, the block returns to IDLE with O_blank=0. An I_start before the timeout restarts immediately, as without the macro.
- Undefined: OVER persists until I_start or reset, and OVER_HOLD_CYC is unused.

Decomposition:
- Shared package game_pkg holds:
  - State encodings (IDLE/RUN/PAUSE/OVER).
  - Default timing constants.
  - Score width (8).
- One sub-module, tick_gen: a programmable down-counter with load value, load, enable and zero-flag. It is used for the move ticks; the blink and hold counters stay inline.

Test Plan (sim params: TICK_BASE=20, TICK_STEP=4, TICK_MIN=8, LEVEL_SHIFT=1, BLINK_CYC=4, OVER_HOLD_CYC=16):
- Start after reset: release reset, I_start at cycle 5 -> RUN entry pulses on O_snake_clear/O_score_clr/O_box_drive for 1 cycle; O_move_tick 20 cycles after entry, then every 20 with score 0.
- Period scaling and clamp: I_score=6 -> tick spacing 8 (20-12); I_score=10 -> 20-20 clamps to 8; I_score=2 -> 16.
- Pause and resume: I_pause 7 cycles after a tick, wait 100 cycles, then I_pause -> no ticks while paused; next tick 13 cycles after resume.
- Collide with eat: I_collide and I_eat in the same cycle -> OVER, no O_box_drive, no tick; O_blank toggles every 4 cycles; I_start -> RUN with all three entry pulses.
- Reset mid-run and start/pause conflict: I_rst high 1 cycle mid-RUN -> O_state=0, all outputs 0 after that edge; then I_start and I_pause together -> RUN.
- GAME_AUTO_RESTART_EN defined: OVER with no start -> IDLE after 16 cycles, O_blank=0. Same build with I_start at cycle 10 of OVER -> RUN immediately.
